carry4_delay_line: RTL and testbench

Carry-chain tapped delay line for the TDC front end. It cascades `STAGES` emulated CARRY4 carry-mux/XOR slices, so a rising edge on the chain input ripples through 4×`STAGES` taps. The taps are sampled on the system clock through a two-flop synchronizer and encoded into a fine-time code with a hit strobe. The CARRY4-compatible ports (CI, CYINIT, DI, S, CO, O) stay combinational, so the block can stand in for the primitive in simulation.

---
 rtl/carry4_delay_line.sv | 108 ++++++++++
 tb/tb_carry4_delay_line.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/carry4_delay_line.sv
// -----------------------------------------------------------------------------
// carry4_delay_line
// Carry-chain tapped delay line for the TDC front end. STAGES emulated CARRY4
// slices are cascaded so a rising edge on the chain input ripples through
// 4*STAGES taps. The taps are brought into the clk domain through two flops,
// then popcount-encoded into a fine-time code alongside a hit strobe.
//
// Optional feature macro: CARRY4_DL_SIM_DELAY_EN
//   defined   : each carry-mux output bit gets a 0.1 ns transport delay, so a
//               mid-ripple sample yields a partial thermometer code (sim only).
//   undefined : zero-delay combinational chain (synthesis build).
//
// Ports
//   clk        system clock, all registers on its rising edge
//   rst        synchronous active-high reset
//   CI         carry cascade input to stage 0
//   CYINIT     carry initialization to stage 0
//   DI[3:0]    carry-mux data inputs, shared by every stage
//   S[3:0]     carry-mux select inputs, shared by every stage
//   CO[3:0]    carry outputs of the last stage (combinational)
//   O[3:0]     XOR outputs of the last stage (combinational)
//   taps       every stage's CO, bit 4k+i = CO[i] of stage k (combinational)
//   taps_q     synchronized tap snapshot (second flop)
//   fine_code  number of ones in taps_q (registered)
//   hit_valid  one-cycle strobe on a 0->1 transition of taps_q[0]
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module carry4_delay_line #(
    parameter  int unsigned STAGES = 4,
    localparam int unsigned TAPS   = 4 * STAGES,
    localparam int unsigned CODE_W = $clog2(TAPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CI,
    input  logic              CYINIT,
    input  logic [3:0]        DI,
    input  logic [3:0]        S,
    output logic [3:0]        CO,
    output logic [3:0]        O,
    output logic [TAPS-1:0]   taps,
    output logic [TAPS-1:0]   taps_q,
    output logic [CODE_W-1:0] fine_code,
    output logic              hit_valid
);

    if (STAGES < 1 || STAGES > 32) begin : g_stages_check
        $error("carry4_delay_line: STAGES must be in 1..32");
    end

    // carry[j] is the carry-in of tap j; carry[j+1] is that tap's carry-out.
    logic [TAPS:0] carry;

    assign carry[0] = CI | CYINIT;

    // Carry-mux per tap; tap j uses select/data bit j%4 of the shared S/DI.
    for (genvar j = 0; j < TAPS; j++) begin : g_tap
        localparam int unsigned BIT_IDX = j % 4;
        logic mux_c;

        assign mux_c = S[BIT_IDX] ? carry[j] : DI[BIT_IDX];

`ifdef CARRY4_DL_SIM_DELAY_EN
        // Transport delay: every input change is propagated, none swallowed.
        logic mux_d;
        always @(mux_c) mux_d <= #0.1 mux_c;
        assign carry[j+1] = mux_d;
`else
        assign carry[j+1] = mux_c;
`endif
    end

    assign taps = carry[TAPS:1];
    assign CO   = carry[TAPS -: 4];
    // XOR outputs use the per-bit carry-ins of the last stage.
    assign O    = S ^ carry[TAPS-1 -: 4];

    logic [TAPS-1:0]   taps_s1;
    logic              prev_tap0;
    logic [CODE_W-1:0] ones_c;

    // Popcount of the synchronized snapshot; bubbles are counted as-is.
    always_comb begin
        ones_c = '0;
        for (int i = 0; i < TAPS; i++) begin
            ones_c = ones_c + CODE_W'(taps_q[i]);
        end
    end

    // Two-flop synchronizer, encoder register and rising-edge hit detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_s1   <= '0;
            taps_q    <= '0;
            prev_tap0 <= 1'b0;
            fine_code <= '0;
            hit_valid <= 1'b0;
        end else begin
            taps_s1   <= taps;
            taps_q    <= taps_s1;
            prev_tap0 <= taps_q[0];
            fine_code <= ones_c;
            hit_valid <= taps_q[0] & ~prev_tap0;
        end
    end

endmodule

// File: tb/tb_carry4_delay_line.sv
// -----------------------------------------------------------------------------
// tb_carry4_delay_line
// Directed vectors with hand-computed expectations. Combinational outputs are
// compared directly after each drive; expected hits (fine code + cycle) are
// queued at stimulus time and a separate monitor pops them whenever hit_valid
// is seen, flagging unexpected or missing strobes.
// -----------------------------------------------------------------------------
`timescale 1ns/10ps

module tb_carry4_delay_line;

    localparam int unsigned STAGES = 4;
    localparam int unsigned TAPS   = 16;
    localparam int unsigned CODE_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ci = 1'b0;
    logic              cyinit = 1'b0;
    logic [3:0]        di = 4'h0;
    logic [3:0]        s = 4'hF;
    logic [3:0]        co;
    logic [3:0]        o;
    logic [TAPS-1:0]   taps;
    logic [TAPS-1:0]   taps_q;
    logic [CODE_W-1:0] fine_code;
    logic              hit_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    carry4_delay_line #(.STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .CI        (ci),
        .CYINIT    (cyinit),
        .DI        (di),
        .S         (s),
        .CO        (co),
        .O         (o),
        .taps      (taps),
        .taps_q    (taps_q),
        .fine_code (fine_code),
        .hit_valid (hit_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hit expected on the third rising edge after a drive made in this cycle.
    task automatic expect_hit(input int code);
        exp_t e;
        e.code = code;
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_comb(input string name, input logic [3:0] e_co,
                              input logic [3:0] e_o, input logic [TAPS-1:0] e_taps);
        #2;
        check({name, "_co"},   32'(co),   32'(e_co));
        check({name, "_o"},    32'(o),    32'(e_o));
        check({name, "_taps"}, 32'(taps), 32'(e_taps));
    endtask

    // Monitor: sampled 1 ns after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (hit_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hit: got hit_valid=1 fine_code=%0d expected no hit (cycle %0d)",
                             fine_code, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("hit_code",  32'(fine_code), 32'(e.code));
                    check("hit_cycle", 32'(cyc),       32'(e.cyc));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_hit: got no hit by cycle %0d expected hit at cycle %0d code %0d",
                         cyc, e.cyc, e.code);
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        // Reset state
        cycles(3);
        check("rst_taps_q",    32'(taps_q),    32'h0);
        check("rst_fine_code", 32'(fine_code), 32'h0);
        check("rst_hit_valid", 32'(hit_valid), 32'h0);
        check_comb("idle", 4'h0, 4'hF, 16'h0000);
        rst = 1'b0;
        cycles(3);
        check("idle_fine_code", 32'(fine_code), 32'h0);

        // Full ripple from CYINIT, held 10 cycles: one pulse only
        cyinit = 1'b1;
        expect_hit(16);
        check_comb("full", 4'hF, 4'h0, 16'hFFFF);
        cycles(10);
        check("full_taps_q",    32'(taps_q),    32'hFFFF);
        check("full_fine_code", 32'(fine_code), 32'd16);

        // Falling edge gives no strobe; re-raise gives a second one
        cyinit = 1'b0;
        check_comb("drop", 4'h0, 4'hF, 16'h0000);
        cycles(5);
        cyinit = 1'b1;
        expect_hit(16);
        check_comb("rerise", 4'hF, 4'h0, 16'hFFFF);
        cycles(6);
        cyinit = 1'b0;
        cycles(5);

        // DI pass-through: every stage CO = DI, tap 0 low so no hit
        s  = 4'h0;
        di = 4'hA;
        check_comb("di_a", 4'hA, 4'h5, 16'hAAAA);
        cycles(4);
        check("di_a_taps_q",    32'(taps_q),    32'hAAAA);
        check("di_a_fine_code", 32'(fine_code), 32'd8);

        // Mixed select/data pattern
        s  = 4'h5;
        di = 4'h2;
        check_comb("mix", 4'h6, 4'h9, 16'h6666);
        cycles(4);
        check("mix_taps_q",    32'(taps_q),    32'h6666);
        check("mix_fine_code", 32'(fine_code), 32'd8);

        // Ripple started from CI instead of CYINIT
        s  = 4'hF;
        di = 4'h0;
        cycles(4);
        ci = 1'b1;
        expect_hit(16);
        check_comb("ci", 4'hF, 4'h0, 16'hFFFF);
        cycles(6);
        ci = 1'b0;
        cycles(5);

        // Reset one cycle after the edge: no pulse during reset, one after
        cyinit = 1'b1;
        cycles(1);
        rst = 1'b1;
        cycles(3);
        check("rstmid_taps_q",    32'(taps_q),    32'h0);
        check("rstmid_hit_valid", 32'(hit_valid), 32'h0);
        rst = 1'b0;
        expect_hit(16);
        cycles(8);
        cyinit = 1'b0;
        cycles(5);

`ifdef CARRY4_DL_SIM_DELAY_EN
        // Edge launched 0.75 ns before a clk edge: 7 taps settled at capture
        #4.25;
        cyinit = 1'b1;
        expect_hit(7);
        cycles(6);
        cyinit = 1'b0;
        cycles(5);
`endif

        cycles(4);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
